// File: rtl/design_sel_pkg.sv
// design_sel_pkg: shared types and constants for the design-select controller.
//   state_t         changeover FSM states (ST_IDLE, ST_BLANK, ST_DRST)
//   SEL_W           default select width
//   NUM_DESIGNS_MAX upper bound on selectable designs (width of DESIGN_MASK)
//   mask_bit()      reads one bit of a design mask using a run-time index
package design_sel_pkg;

  localparam int SEL_W           = 3;
  localparam int NUM_DESIGNS_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRST  = 2'd2
  } state_t;

  // Returns mask[idx]. The comparison against every constant position avoids
  // a variable-width part select, and any idx outside the mask returns 0.
  function automatic logic mask_bit(input logic [NUM_DESIGNS_MAX-1:0] mask,
                                    input int idx);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_DESIGNS_MAX; j++) begin
      if (idx == j) hit = mask[j];
    end
    return hit;
  endfunction

endpackage

// File: rtl/design_sel_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, debounce filter and rising-edge pulse for
// the "next design" push-button.
//   clk, rst   system clock, asynchronous active-high reset
//   btn_in     raw, asynchronous, bouncy button (active-high)
//   press      1-cycle pulse, high in the first cycle the debounced level is 1
// The debounced level follows the synchronized input only after the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_m;
  logic             btn_s;
  logic             btn_stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m      <= 1'b0;
      btn_s      <= 1'b0;
      btn_stable <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      btn_m <= btn_in;
      btn_s <= btn_m;
      press <= 1'b0;
      if (btn_s == btn_stable) begin
        // Any sample agreeing with the stable level restarts the run.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_stable <= btn_s;
        press      <= btn_s;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/design_sel_ctrl.sv
// design_sel_ctrl: sequences glitch-free switching of the design multiplexer.
//   clk             system clock
//   rst             asynchronous active-high reset
//   sel_strap_in    strap pins (asynchronous)
//   next_btn_in     "next design" button (asynchronous, bouncy)
//   design_sel_out  select to the multiplexer
//   mux_blank_out   forces multiplexer outputs to 0 while high
//   design_rst_out  active-high reset to all user designs
//   busy_out        changeover in progress
// Optional feature macro: DESIGN_SEL_BUTTON_EN compiles in the button path
// (synchronizer, debounce, next-enabled-index search). Without it only strap
// requests are served.
// Handshake: there is none; a request is taken only in ST_IDLE and every
// changeover runs BLANK (old select, blanked) then DRST (new select, blanked,
// designs in reset) before returning to IDLE.
module design_sel_ctrl #(
  parameter int NUM_DESIGNS     = 8,
  parameter int SEL_W           = design_sel_pkg::SEL_W,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLANK_CYCLES    = 16,
  parameter int RESET_CYCLES    = 16,
  parameter logic [design_sel_pkg::NUM_DESIGNS_MAX-1:0] DESIGN_MASK = 8'hFF,
  parameter int RESET_SEL       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_strap_in,
  input  logic             next_btn_in,
  output logic [SEL_W-1:0] design_sel_out,
  output logic             mux_blank_out,
  output logic             design_rst_out,
  output logic             busy_out
);

  import design_sel_pkg::*;

  localparam int CNT_MAX = (BLANK_CYCLES > RESET_CYCLES) ? BLANK_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_INIT   = SEL_W'(RESET_SEL);

  logic [SEL_W-1:0] strap_m;
  logic [SEL_W-1:0] strap_s;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] target_nxt;
  logic [SEL_W-1:0] last_strap;
  logic [SEL_W-1:0] last_strap_nxt;

  logic             strap_req;
  logic             strap_ok;
  logic             btn_press;
  logic             btn_found;
  logic [SEL_W-1:0] btn_next;

  // ---------------------------------------------------------------- button
`ifdef DESIGN_SEL_BUTTON_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_in(next_btn_in),
    .press (btn_press)
  );

  // Search downwards so the last hit kept is the nearest enabled index
  // after the current select (wrapping modulo NUM_DESIGNS).
  always_comb begin
    btn_found = 1'b0;
    btn_next  = sel;
    for (int i = NUM_DESIGNS - 1; i >= 1; i--) begin
      if (mask_bit(DESIGN_MASK, (int'(sel) + i) % NUM_DESIGNS)) begin
        btn_found = 1'b1;
        btn_next  = SEL_W'((int'(sel) + i) % NUM_DESIGNS);
      end
    end
  end
`else
  logic unused_btn;
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  assign unused_btn = next_btn_in;
  assign btn_press  = 1'b0;
  assign btn_found  = 1'b0;
  assign btn_next   = '0;
`endif

  // ----------------------------------------------------- strap synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strap_m <= '0;
      strap_s <= '0;
    end else begin
      strap_m <= sel_strap_in;
      strap_s <= strap_m;
    end
  end

  assign strap_req = (strap_s != last_strap);
  assign strap_ok  = (int'(strap_s) < NUM_DESIGNS) &&
                     mask_bit(DESIGN_MASK, int'(strap_s));

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    target_nxt     = target;
    last_strap_nxt = last_strap;
    case (state)
      ST_IDLE: begin
        if (strap_req) begin
          // A strap change always consumes the button press of the same cycle,
          // even when the strap value itself is rejected.
          last_strap_nxt = strap_s;
          if (strap_ok && (strap_s != sel)) begin
            target_nxt = strap_s;
            state_nxt  = ST_BLANK;
            cnt_nxt    = BLANK_LOAD;
          end
        end else if (btn_press && btn_found && (btn_next != sel)) begin
          target_nxt = btn_next;
          state_nxt  = ST_BLANK;
          cnt_nxt    = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (cnt == '0) begin
          sel_nxt   = target;
          state_nxt = ST_DRST;
          cnt_nxt   = RESET_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DRST: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------- state and output registers
  // Outputs are registered from the next state so they line up exactly with
  // the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_DRST;
      cnt            <= RESET_LOAD;
      sel            <= SEL_INIT;
      target         <= SEL_INIT;
      last_strap     <= '0;
      mux_blank_out  <= 1'b1;
      design_rst_out <= 1'b1;
      busy_out       <= 1'b1;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      sel            <= sel_nxt;
      target         <= target_nxt;
      last_strap     <= last_strap_nxt;
      mux_blank_out  <= (state_nxt != ST_IDLE);
      design_rst_out <= (state_nxt == ST_DRST);
      busy_out       <= (state_nxt != ST_IDLE);
    end
  end

  assign design_sel_out = sel;

endmodule

// File: tb/tb_design_sel_ctrl.sv
// tb_design_sel_ctrl: bench for design_sel_ctrl. Two instances share the
// pins: u_a with all designs enabled, u_b with designs 1 and 7 masked out.
// Button sequences run only when DESIGN_SEL_BUTTON_EN is defined.
module tb_design_sel_ctrl;

  localparam int B  = 3;
  localparam int R  = 2;
  localparam int D  = 4;
  localparam int NR = 300;

  // --------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  logic [2:0] strap = 3'd0;
  logic       btn   = 1'b0;

  logic [2:0] sel1, sel2;
  logic       blank1, blank2, drst1, drst2, busy1, busy2;

  design_sel_ctrl #(
    .DEBOUNCE_CYCLES(D), .BLANK_CYCLES(B), .RESET_CYCLES(R),
    .DESIGN_MASK(8'hFF), .RESET_SEL(0)
  ) u_a (
    .clk(clk), .rst(rst), .sel_strap_in(strap), .next_btn_in(btn),
    .design_sel_out(sel1), .mux_blank_out(blank1),
    .design_rst_out(drst1), .busy_out(busy1)
  );

  design_sel_ctrl #(
    .DEBOUNCE_CYCLES(D), .BLANK_CYCLES(B), .RESET_CYCLES(R),
    .DESIGN_MASK(8'h7D), .RESET_SEL(0)
  ) u_b (
    .clk(clk), .rst(rst), .sel_strap_in(strap), .next_btn_in(btn),
    .design_sel_out(sel2), .mux_blank_out(blank2),
    .design_rst_out(drst2), .busy_out(busy2)
  );

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] exp_q1[$];
  logic [5:0] exp_q2[$];
  logic [2:0] pins[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // {sel, blank, drst, busy}
  function automatic logic [5:0] ev(input int s, input bit bl, input bit dr, input bit bz);
    return {3'(s), bl, dr, bz};
  endfunction
  function automatic logic [5:0] v1();
    return {sel1, blank1, drst1, busy1};
  endfunction
  function automatic logic [5:0] v2();
    return {sel2, blank2, drst2, busy2};
  endfunction

  // ---------------------------------------------------------- driver tasks
  // Loops sit just after a rising edge, drive, sample at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int r1, output int r2, output int bz);
    logic p1, p2;
    p1 = blank1; p2 = blank2; r1 = 0; r2 = 0; bz = 0;
    repeat (n) begin
      @(negedge clk);
      if (blank1 && !p1) r1++;
      if (blank2 && !p2) r2++;
      if (busy1 || busy2) bz++;
      p1 = blank1; p2 = blank2;
      tick();
    end
  endtask

  typedef struct {
    logic [2:0] strap;
    logic [2:0] sel1;
    int         sw1;
    logic [2:0] sel2;
    int         sw2;
  } vec_t;
  vec_t tbl[6];

  // reference model state (plain timeline arithmetic)
  int m_sel, m_last, m_start, m_tgt, m_s, m_ph;
  logic [7:0] m_mask;
  logic [5:0] m_e;
  int r1, r2, bz;

  initial begin
    // strap table: {pin, sel a, changeovers a, sel b, changeovers b}
    tbl[0] = '{3'd1, 3'd1, 1, 3'd5, 0};
    tbl[1] = '{3'd5, 3'd5, 1, 3'd5, 0};
    tbl[2] = '{3'd7, 3'd7, 1, 3'd5, 0};
    tbl[3] = '{3'd2, 3'd2, 1, 3'd2, 1};
    tbl[4] = '{3'd0, 3'd0, 1, 3'd0, 1};
    tbl[5] = '{3'd6, 3'd6, 1, 3'd6, 1};

    // ---- reset and release
    repeat (3) tick();
    @(negedge clk);
    check("in_reset", 32'(v1()), 32'(ev(0, 1, 1, 1)));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("release_c%0d", c), 32'(v1()), 32'(ev(0, c < 2, c < 2, c < 2)));
      tick();
    end

    // ---- strap 0 -> 5, cycle-exact
    strap = 3'd5;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check($sformatf("strap5_c%0d", c), 32'(v1()),
            32'(ev((c >= 6) ? 5 : 0, c >= 3 && c <= 7, c >= 6 && c <= 7, c >= 3 && c <= 7)));
      tick();
    end
    check("strap5_b_sel", 32'(sel2), 32'd5);

    // ---- strap table
    for (int i = 0; i < 6; i++) begin
      strap = tbl[i].strap;
      run(14, r1, r2, bz);
      check($sformatf("tbl%0d_sel_a", i), 32'(sel1), 32'(tbl[i].sel1));
      check($sformatf("tbl%0d_sw_a", i), 32'(r1), 32'(tbl[i].sw1));
      check($sformatf("tbl%0d_sel_b", i), 32'(sel2), 32'(tbl[i].sel2));
      check($sformatf("tbl%0d_sw_b", i), 32'(r2), 32'(tbl[i].sw2));
    end

    // ---- strap changes during BLANK: 6 -> 3, then back to 6 after one idle cycle
    strap = 3'd3;
    for (int c = 0; c < 16; c++) begin
      if (c == 4) strap = 3'd6;
      @(negedge clk);
      check($sformatf("midblank_c%0d", c), 32'(v1()),
            32'(ev((c >= 6 && c < 12) ? 3 : 6,
                   (c >= 3 && c <= 7) || (c >= 9 && c <= 13),
                   (c == 6) || (c == 7) || (c == 12) || (c == 13),
                   (c >= 3 && c <= 7) || (c >= 9 && c <= 13))));
      tick();
    end

    // ---- rst pulsed during DRST of a switch to 4
    strap = 3'd4;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check("drst_before_rst", 32'(v1()), 32'(ev(4, 1, 1, 1)));
    #2 rst = 1'b1;
    #1;
    check("rst_abort", 32'(v1()), 32'(ev(0, 1, 1, 1)));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("rerun_c%0d", c), 32'(v1()),
            32'(ev((c >= 6) ? 4 : 0, c < 2 || (c >= 3 && c <= 7),
                   c < 2 || c == 6 || c == 7, c < 2 || (c >= 3 && c <= 7))));
      tick();
    end

`ifdef DESIGN_SEL_BUTTON_EN
    // ---- button: a at 7 wraps to 0, b at 0 skips masked 1 to reach 2
    strap = 3'd0;
    run(14, r1, r2, bz);
    strap = 3'd7;
    run(14, r1, r2, bz);
    check("btn_pre_a", 32'(sel1), 32'd7);
    check("btn_pre_b", 32'(sel2), 32'd0);
    btn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) btn = 1'b0;
      @(negedge clk);
      check($sformatf("btn_a_c%0d", c), 32'(v1()),
            32'(ev((c >= 10) ? 0 : 7, c >= 7 && c <= 11, c >= 10 && c <= 11, c >= 7 && c <= 11)));
      check($sformatf("btn_b_c%0d", c), 32'(v2()),
            32'(ev((c >= 10) ? 2 : 0, c >= 7 && c <= 11, c >= 10 && c <= 11, c >= 7 && c <= 11)));
      tick();
    end
    run(8, r1, r2, bz);

    // ---- bounce pulses of 1..3 cycles
    for (int len = 1; len <= 3; len++) begin
      btn = 1'b1;
      run(len, r1, r2, bz);
      check($sformatf("bounce%0d_busy_hi", len), 32'(bz), 32'd0);
      btn = 1'b0;
      run(8, r1, r2, bz);
      check($sformatf("bounce%0d_busy_lo", len), 32'(bz), 32'd0);
    end
    check("bounce_sel_a", 32'(sel1), 32'd0);

    // ---- strap 3 and button press land in the same cycle
    btn = 1'b1;
    run(4, r1, r2, bz);
    strap = 3'd3;
    run(6, r1, r2, bz);
    btn = 1'b0;
    begin
      int s1, s2;
      s1 = r1; s2 = r2;
      run(14, r1, r2, bz);
      check("both_sw_a", 32'(s1 + r1), 32'd1);
      check("both_sw_b", 32'(s2 + r2), 32'd1);
    end
    check("both_sel_a", 32'(sel1), 32'd3);
    check("both_sel_b", 32'(sel2), 32'd3);
`else
    // ---- button path absent: toggling must be inert
    for (int c = 0; c < 40; c++) begin
      btn = 1'($urandom_range(0, 1));
      run(1 + $urandom_range(0, 5), r1, r2, bz);
      check($sformatf("nobtn_busy%0d", c), 32'(bz), 32'd0);
    end
    btn = 1'b0;
    check("nobtn_sel_a", 32'(sel1), 32'd4);
    check("nobtn_sel_b", 32'(sel2), 32'd4);
`endif

    // ---- randomized strap stream against the timeline model
    rst = 1'b1;
    strap = 3'd0;
    btn = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    run(10, r1, r2, bz);

    while (pins.size() < NR) begin
      int v, h;
      v = $urandom_range(0, 7);
      h = $urandom_range(1, 14);
      repeat (h) pins.push_back(3'(v));
    end
    for (int d = 0; d < 2; d++) begin
      m_mask  = (d == 0) ? 8'hFF : 8'h7D;
      m_sel   = 0;
      m_last  = 0;
      m_start = -1;
      m_tgt   = 0;
      for (int t = 0; t < NR; t++) begin
        // a changeover decided in cycle s blanks s+1..s+B+R, new select from s+B+1
        if (m_start >= 0 && t - m_start > B + R) begin
          m_sel   = m_tgt;
          m_start = -1;
        end
        if (m_start >= 0) begin
          m_ph = t - m_start;
          m_e  = ev((m_ph > B) ? m_tgt : m_sel, 1, m_ph > B, 1);
        end else begin
          m_e = ev(m_sel, 0, 0, 0);
          m_s = (t >= 2) ? int'(pins[t-2]) : 0;
          if (m_s != m_last) begin
            m_last = m_s;
            if (m_mask[3'(m_s)] && m_s != m_sel) begin
              m_start = t;
              m_tgt   = m_s;
            end
          end
        end
        if (d == 0) exp_q1.push_back(m_e);
        else        exp_q2.push_back(m_e);
      end
    end

    for (int t = 0; t < NR; t++) begin
      tick();
      strap = pins[t];
      @(negedge clk);
      check($sformatf("rand_a_t%0d", t), 32'(v1()), 32'(exp_q1.pop_front()));
      check($sformatf("rand_b_t%0d", t), 32'(v2()), 32'(exp_q2.pop_front()));
    end

    // ---- final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
